// File: rtl/set_time_ctrl.sv
// Set-time screen controller: maps debounced up/down/confirm presses to max_time and locks it for the match.
// Define SET_TIME_AUTO_REPEAT_EN to enable hold-to-repeat stepping in SET mode.
module set_time_ctrl #(
  parameter int STEP          = 5,
  parameter int MIN_TIME      = 30,
  parameter int MAX_TIME      = 255,
  parameter int DEFAULT_TIME  = 60,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       unlock,
  output logic [7:0] max_time,
  output logic       locked,
  output logic       start
);

  // state     | meaning
  // ST_SET    | value editable with up/down, confirm locks and starts the match
  // ST_LOCKED | match running, value frozen until unlock
  typedef enum logic [0:0] {ST_SET, ST_LOCKED} state_t;

  if (STEP < 1 || STEP > 255 || MIN_TIME < 0 || MIN_TIME > DEFAULT_TIME ||
      DEFAULT_TIME > MAX_TIME || MAX_TIME > 255 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("set_time_ctrl: illegal parameter set");
  end

  state_t     state_q, state_d;
  logic [7:0] time_q, time_d;
  logic       start_q, start_d;
  logic       up_prev_q, down_prev_q, confirm_prev_q;
  logic       up_press, down_press, confirm_press;
  logic [8:0] time_sum;
  logic [7:0] time_inc, time_dec;

`ifdef SET_TIME_AUTO_REPEAT_EN
  localparam int RPT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_act_q, rpt_act_d;
`endif

  assign up_press      = btn_up & ~up_prev_q;
  assign down_press    = btn_down & ~down_prev_q;
  assign confirm_press = btn_confirm & ~confirm_prev_q;

  // Saturating step results, computed 9 bits wide so neither end can wrap.
  always_comb begin
    time_sum = {1'b0, time_q} + 9'(STEP);
    time_inc = (time_sum > 9'(MAX_TIME)) ? 8'(MAX_TIME) : time_sum[7:0];
    time_dec = ({1'b0, time_q} < 9'(MIN_TIME + STEP)) ? 8'(MIN_TIME) : (time_q - 8'(STEP));
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    start_d = 1'b0;
`ifdef SET_TIME_AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
    rpt_act_d = 1'b0;
`endif
    case (state_q)
      ST_SET: begin
        if (confirm_press) begin
          state_d = ST_LOCKED;
          start_d = 1'b1;
        end else if (!(btn_up && btn_down)) begin
          if (up_press) begin
            time_d = time_inc;
          end else if (down_press) begin
            time_d = time_dec;
          end
`ifdef SET_TIME_AUTO_REPEAT_EN
          // Down-counter runs only while the button that armed it stays the only one held.
          if (up_press || down_press) begin
            rpt_act_d = 1'b1;
            rpt_cnt_d = CNT_W'(HOLD_DELAY - 1);
          end else if (rpt_act_q && (btn_up || btn_down)) begin
            rpt_act_d = 1'b1;
            if (rpt_cnt_q == '0) begin
              time_d    = btn_up ? time_inc : time_dec;
              rpt_cnt_d = CNT_W'(REPEAT_PERIOD - 1);
            end else begin
              rpt_cnt_d = rpt_cnt_q - 1'b1;
            end
          end
`endif
        end
      end
      ST_LOCKED: begin
        if (unlock) begin
          state_d = ST_SET;
        end
      end
      default: begin
        state_d = ST_SET;
      end
    endcase
`ifdef SET_TIME_AUTO_REPEAT_EN
    if (!rpt_act_d) begin
      rpt_cnt_d = '0;
    end
`endif
  end

  // Previous samples reset high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_SET;
      time_q         <= 8'(DEFAULT_TIME);
      start_q        <= 1'b0;
      up_prev_q      <= 1'b1;
      down_prev_q    <= 1'b1;
      confirm_prev_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      time_q         <= time_d;
      start_q        <= start_d;
      up_prev_q      <= btn_up;
      down_prev_q    <= btn_down;
      confirm_prev_q <= btn_confirm;
    end
  end

`ifdef SET_TIME_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_act_q <= rpt_act_d;
    end
  end
`endif

  assign max_time = time_q;
  assign locked   = (state_q == ST_LOCKED);
  assign start    = start_q;

endmodule

// File: tb/tb_set_time_ctrl.sv
// Directed self-checking bench for set_time_ctrl (MAX_TIME=100, HOLD_DELAY=4, REPEAT_PERIOD=2).
module tb_set_time_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_up, btn_down, btn_confirm, unlock;
  logic [7:0] max_time;
  logic       locked, start;

  int checks = 0;
  int errors = 0;

  set_time_ctrl #(
    .STEP(5), .MIN_TIME(30), .MAX_TIME(100), .DEFAULT_TIME(60),
    .HOLD_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_confirm(btn_confirm), .unlock(unlock),
    .max_time(max_time), .locked(locked), .start(start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_val);
    checks++;
    if (obs != exp_val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 up, 1 down, 2 confirm
  task automatic pulse_btn(input int sel);
    case (sel)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      default: btn_confirm = 1'b1;
    endcase
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_confirm = 1'b0;
    tick();
  endtask

  initial begin
    int exp_t;
    reset_n = 1'b0; btn_up = 1'b1; btn_down = 1'b0; btn_confirm = 1'b0; unlock = 1'b0;
    tick(); tick();
    chk("rst_time", max_time, 60);
    chk("rst_locked", locked, 0);
    chk("rst_start", start, 0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("held_through_rst", max_time, 60);
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    chk("first_press", max_time, 65);
    btn_up = 1'b0; tick();

    for (int i = 1; i <= 11; i++) begin
      pulse_btn(0);
      exp_t = (65 + 5 * i > 100) ? 100 : 65 + 5 * i;
      chk($sformatf("up_%0d", i), max_time, exp_t);
    end
    for (int i = 1; i <= 16; i++) begin
      pulse_btn(1);
      exp_t = (100 - 5 * i < 30) ? 30 : 100 - 5 * i;
      chk($sformatf("down_%0d", i), max_time, exp_t);
    end

    for (int i = 0; i < 6; i++) pulse_btn(0);
    chk("pre_both", max_time, 60);
    btn_up = 1'b1; btn_down = 1'b1; tick();
    chk("both_edge", max_time, 60);
    tick();
    chk("both_held", max_time, 60);
    btn_down = 1'b0; tick();
    chk("down_release", max_time, 60);
    tick(); tick(); tick(); tick(); tick();
    chk("up_left_held", max_time, 60);
    btn_up = 1'b0; tick();

    for (int i = 0; i < 6; i++) pulse_btn(0);
    chk("pre_confirm", max_time, 90);
    btn_confirm = 1'b1; tick();
    chk("confirm_start", start, 1);
    chk("confirm_locked", locked, 1);
    tick();
    chk("start_one_cycle", start, 0);
    btn_confirm = 1'b0; tick();
    for (int s = 0; s < 3; s++) begin
      pulse_btn(s);
      chk($sformatf("locked_time_%0d", s), max_time, 90);
      chk($sformatf("locked_start_%0d", s), start, 0);
      chk($sformatf("locked_stays_%0d", s), locked, 1);
    end
    unlock = 1'b1; tick();
    chk("unlock_locked", locked, 0);
    chk("unlock_time", max_time, 90);
    unlock = 1'b0; tick();
    pulse_btn(0);
    chk("up_after_unlock", max_time, 95);

    for (int i = 0; i < 7; i++) pulse_btn(1);
    chk("pre_confirm_up", max_time, 60);
    btn_confirm = 1'b1; btn_up = 1'b1; tick();
    chk("cu_locked", locked, 1);
    chk("cu_start", start, 1);
    chk("cu_time", max_time, 60);
    btn_confirm = 1'b0; tick();
    chk("cu_start_drop", start, 0);
    unlock = 1'b1; tick();
    chk("cu_unlock", locked, 0);
    unlock = 1'b0; tick();
    chk("held_across_unlock", max_time, 60);
    tick(); tick(); tick(); tick(); tick();
    chk("held_across_unlock_late", max_time, 60);
    btn_up = 1'b0; tick();

    btn_up = 1'b1; tick();
    chk("hold_0", max_time, 65);
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifdef SET_TIME_AUTO_REPEAT_EN
      exp_t = (k < 4) ? 65 : (k < 6) ? 70 : (k < 8) ? 75 : 80;
`else
      exp_t = 65;
`endif
      chk($sformatf("hold_%0d", k), max_time, exp_t);
    end
    btn_up = 1'b0; tick(); tick(); tick();
    chk("hold_release", max_time, exp_t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
